// File: rtl/sysid_reader.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words
// and checks both against the build constants.
module sysid_reader #(
    parameter logic [31:0] EXPECTED_ID        = 32'd58678540,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1283946474,
    parameter int unsigned READ_LATENCY       = 0,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] sys_id,
    output logic [31:0] timestamp,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        LAT_ID,
        RD_TS,
        LAT_TS,
        FIN
    } state_t;

    localparam logic [2:0]  LAT       = 3'(READ_LATENCY);
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] wait_q, wait_d;
    logic [2:0]  lat_q, lat_d;
    logic [31:0] sys_id_q, sys_id_d;
    logic [31:0] ts_q, ts_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        tmo_q, tmo_d;

    // State, timers, captured words and flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            lat_q    <= '0;
            sys_id_q <= '0;
            ts_q     <= '0;
            id_ok_q  <= 1'b0;
            ts_ok_q  <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            lat_q    <= lat_d;
            sys_id_q <= sys_id_d;
            ts_q     <= ts_d;
            id_ok_q  <= id_ok_d;
            ts_ok_q  <= ts_ok_d;
            tmo_q    <= tmo_d;
        end
    end

    // Next-state: two reads, each with stall timeout and fixed latency
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        lat_d    = lat_q;
        sys_id_d = sys_id_q;
        ts_d     = ts_q;
        id_ok_d  = id_ok_q;
        ts_ok_d  = ts_ok_q;
        tmo_d    = tmo_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD_ID;
                    wait_d  = '0;
                    id_ok_d = 1'b0;
                    ts_ok_d = 1'b0;
                    tmo_d   = 1'b0;
                end
            end
            RD_ID: begin
                if (!avm_waitrequest) begin
                    if (LAT == 3'd0) begin
                        sys_id_d = avm_readdata;
                        id_ok_d  = (avm_readdata == EXPECTED_ID);
                        wait_d   = '0;
                        state_d  = RD_TS;
                    end else begin
                        lat_d   = 3'd1;
                        state_d = LAT_ID;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            LAT_ID: begin
                if (lat_q == LAT) begin
                    sys_id_d = avm_readdata;
                    id_ok_d  = (avm_readdata == EXPECTED_ID);
                    wait_d   = '0;
                    state_d  = RD_TS;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            RD_TS: begin
                if (!avm_waitrequest) begin
                    if (LAT == 3'd0) begin
                        ts_d    = avm_readdata;
                        ts_ok_d = (avm_readdata == EXPECTED_TIMESTAMP);
                        state_d = FIN;
                    end else begin
                        lat_d   = 3'd1;
                        state_d = LAT_TS;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            LAT_TS: begin
                if (lat_q == LAT) begin
                    ts_d    = avm_readdata;
                    ts_ok_d = (avm_readdata == EXPECTED_TIMESTAMP);
                    state_d = FIN;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign avm_read    = (state_q == RD_ID) || (state_q == RD_TS);
    assign avm_address = (state_q == RD_TS) || (state_q == LAT_TS);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == FIN);
    assign sys_id      = sys_id_q;
    assign timestamp   = ts_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_sysid_reader.sv
// Bench for sysid_reader: three instances (plain, latency 2, timeout 4)
// against a stalling/latency slave and a cycle-count reference model.
module tb_sysid_reader;

    localparam logic [31:0] EXP_ID = 32'd58678540;
    localparam logic [31:0] EXP_TS = 32'd1283946474;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [2:0]       start;
    logic [2:0]       addr;
    logic [2:0]       rd;
    logic [2:0]       wr;
    logic [2:0][31:0] rdata;
    logic [2:0]       busy;
    logic [2:0]       done;
    logic [2:0][31:0] sid;
    logic [2:0][31:0] tsw;
    logic [2:0]       iok;
    logic [2:0]       tok;
    logic [2:0]       terr;

    logic [2:0][31:0] id_v;
    logic [2:0][31:0] ts_v;
    int               stall_cfg [3][2];
    logic [2:0][15:0] scnt;
    logic [2:0][2:0]  pend;
    logic [2:0]       paddr;

    logic [31:0] prev_id [3];
    logic [31:0] prev_ts [3];

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    function automatic int lat_of(input int i);
        return (i == 1) ? 2 : 0;
    endfunction

    function automatic int tmo_of(input int i);
        return (i == 2) ? 4 : 255;
    endfunction

    sysid_reader #(.READ_LATENCY(0), .TIMEOUT_CYCLES(255)) u_d0 (
        .clock(clock), .reset_n(reset_n), .start(start[0]),
        .avm_address(addr[0]), .avm_read(rd[0]),
        .avm_waitrequest(wr[0]), .avm_readdata(rdata[0]),
        .busy(busy[0]), .done(done[0]), .sys_id(sid[0]),
        .timestamp(tsw[0]), .id_ok(iok[0]), .ts_ok(tok[0]),
        .timeout_err(terr[0])
    );

    sysid_reader #(.READ_LATENCY(2), .TIMEOUT_CYCLES(255)) u_d1 (
        .clock(clock), .reset_n(reset_n), .start(start[1]),
        .avm_address(addr[1]), .avm_read(rd[1]),
        .avm_waitrequest(wr[1]), .avm_readdata(rdata[1]),
        .busy(busy[1]), .done(done[1]), .sys_id(sid[1]),
        .timestamp(tsw[1]), .id_ok(iok[1]), .ts_ok(tok[1]),
        .timeout_err(terr[1])
    );

    sysid_reader #(.READ_LATENCY(0), .TIMEOUT_CYCLES(4)) u_d2 (
        .clock(clock), .reset_n(reset_n), .start(start[2]),
        .avm_address(addr[2]), .avm_read(rd[2]),
        .avm_waitrequest(wr[2]), .avm_readdata(rdata[2]),
        .busy(busy[2]), .done(done[2]), .sys_id(sid[2]),
        .timestamp(tsw[2]), .id_ok(iok[2]), .ts_ok(tok[2]),
        .timeout_err(terr[2])
    );

    // Slave: stall counter per read, latency pipeline per instance
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scnt  <= '0;
            pend  <= '0;
            paddr <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (pend[i] != 3'd0) pend[i] <= pend[i] - 3'd1;
                if (rd[i]) begin
                    if (wr[i]) begin
                        scnt[i] <= scnt[i] + 16'd1;
                    end else begin
                        scnt[i]  <= '0;
                        pend[i]  <= 3'(lat_of(i));
                        paddr[i] <= addr[i];
                    end
                end else begin
                    scnt[i] <= '0;
                end
            end
        end
    end

    // Slave: waitrequest and readdata (garbage outside the valid cycle)
    always_comb begin
        wr    = '0;
        rdata = '0;
        for (int i = 0; i < 3; i++) begin
            wr[i] = rd[i] && (int'(scnt[i]) < stall_cfg[i][addr[i]]);
            if (lat_of(i) == 0)
                rdata[i] = addr[i] ? ts_v[i] : id_v[i];
            else if (pend[i] == 3'd1)
                rdata[i] = paddr[i] ? ts_v[i] : id_v[i];
            else
                rdata[i] = 32'hBAD0_0000 + 32'(i);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run(input int i, input int s_id, input int s_ts,
                       input logic [31:0] iv, input logic [31:0] tv,
                       input bit repulse);
        int L, T, e_done, e_n0, e_n1, n0, n1, got, extra;
        logic [31:0] e_id, e_ts;
        logic e_iok, e_tok, e_to;
        L = lat_of(i);
        T = tmo_of(i);
        if (s_id >= T) begin
            e_done = 1 + T;
            e_n0 = T; e_n1 = 0;
            e_id = prev_id[i]; e_ts = prev_ts[i];
            e_iok = 0; e_tok = 0; e_to = 1;
        end else if (s_ts >= T) begin
            e_done = 2 + s_id + L + T;
            e_n0 = s_id + 1; e_n1 = T;
            e_id = iv; e_ts = prev_ts[i];
            e_iok = (iv == EXP_ID); e_tok = 0; e_to = 1;
        end else begin
            e_done = 3 + 2 * L + s_id + s_ts;
            e_n0 = s_id + 1; e_n1 = s_ts + 1;
            e_id = iv; e_ts = tv;
            e_iok = (iv == EXP_ID); e_tok = (tv == EXP_TS); e_to = 0;
        end
        id_v[i] = iv;
        ts_v[i] = tv;
        stall_cfg[i][0] = s_id;
        stall_cfg[i][1] = s_ts;
        n0 = 0; n1 = 0; got = -1;
        @(negedge clock);
        start[i] = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clock);
            if (k == 1) start[i] = 1'b0;
            if (repulse && k == 2) start[i] = 1'b1;
            if (repulse && k == 3) start[i] = 1'b0;
            if (rd[i]) begin
                if (addr[i]) n1++;
                else n0++;
            end
            if (done[i]) begin
                got = k;
                break;
            end
        end
        chk("done_cycle", 32'(got), 32'(e_done));
        chk("reads_addr0", 32'(n0), 32'(e_n0));
        chk("reads_addr1", 32'(n1), 32'(e_n1));
        chk("sys_id", sid[i], e_id);
        chk("timestamp", tsw[i], e_ts);
        chk("id_ok", 32'(iok[i]), 32'(e_iok));
        chk("ts_ok", 32'(tok[i]), 32'(e_tok));
        chk("timeout_err", 32'(terr[i]), 32'(e_to));
        if (repulse) start[i] = 1'b1;
        @(negedge clock);
        start[i] = 1'b0;
        chk("busy_after_fin", 32'(busy[i]), 32'd0);
        extra = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (done[i] || busy[i]) extra++;
        end
        chk("no_extra_run", 32'(extra), 32'd0);
        chk("hold_id_ok", 32'(iok[i]), 32'(e_iok));
        prev_id[i] = e_id;
        prev_ts[i] = e_ts;
    endtask

    initial begin
        int s0, s1, inst;
        logic [31:0] iv, tv;
        bit seen;
        reset_n = 1'b0;
        start   = '0;
        id_v    = '0;
        ts_v    = '0;
        for (int i = 0; i < 3; i++) begin
            stall_cfg[i][0] = 0;
            stall_cfg[i][1] = 0;
            prev_id[i] = '0;
            prev_ts[i] = '0;
        end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            chk("idle_outputs",
                {rd, addr, busy, done, iok, tok, terr, 11'd0},
                32'd0);
            chk("idle_words", sid[0] | tsw[0] | sid[1] | tsw[1]
                | sid[2] | tsw[2], 32'd0);
        end

        run(0, 0, 0, EXP_ID, EXP_TS, 0);
        run(0, 0, 0, EXP_ID, 32'h0000_0001, 0);
        run(1, 3, 3, EXP_ID, EXP_TS, 0);
        run(2, 1000, 1000, EXP_ID, EXP_TS, 0);
        run(2, 3, 0, EXP_ID, EXP_TS, 0);
        run(2, 0, 4, EXP_ID, EXP_TS, 0);
        run(0, 0, 0, EXP_ID, EXP_TS, 1);
        run(1, 1, 0, 32'h1234_5678, EXP_TS, 1);

        for (int n = 0; n < 24; n++) begin
            inst = int'($urandom_range(0, 2));
            if (inst == 2) begin
                s0 = int'($urandom_range(0, 5));
                s1 = int'($urandom_range(0, 5));
            end else begin
                s0 = int'($urandom_range(0, 3));
                s1 = int'($urandom_range(0, 3));
            end
            iv = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
            tv = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
            run(inst, s0, s1, iv, tv, $urandom_range(0, 1) == 1);
        end

        stall_cfg[0][0] = 0;
        stall_cfg[0][1] = 10;
        id_v[0] = EXP_ID;
        ts_v[0] = EXP_TS;
        @(negedge clock);
        start[0] = 1'b1;
        @(negedge clock);
        start[0] = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (rd[0] && addr[0]) begin
                seen = 1;
                break;
            end
            @(negedge clock);
        end
        chk("reached_rd_ts", 32'(seen), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_read", 32'(rd[0]), 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_flags", {29'd0, iok[0], tok[0], terr[0]}, 32'd0);
        chk("rst_sys_id", sid[0], 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            prev_id[i] = '0;
            prev_ts[i] = '0;
        end
        run(0, 0, 0, EXP_ID, EXP_TS, 0);
        run(1, 0, 2, EXP_ID, EXP_TS, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
